vga_timing_gen: RTL and testbench

- Parametrised, registered successor to the fixed 800x600 sync generator.
- Produces hsync, vsync, video_on and pixel coordinates for any mode, using per-mode porch and sync parameters and selectable sync polarity.
- Advances only on a pixel-clock enable, so it can run from a faster system clock.
- Adds one-cycle start-of-frame and end-of-line strobes for the downstream pixel pipeline and frame buffer reader.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_timing_gen_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default SVGA mode constants and counter width helper
package vga_timing_pkg;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 32;
    localparam int SVGA_H_SYNC   = 64;
    localparam int SVGA_H_BP     = 152;
    localparam int SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 3;
    localparam int SVGA_V_BP     = 24;
    localparam int SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// rtl/vga_timing_gen_axis_counter.sv - one timing axis: wrapping counter with active/sync decode
module timing_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = SVGA_H_ACTIVE,
    parameter int FP     = SVGA_H_FP,
    parameter int SYNC   = SVGA_H_SYNC,
    parameter int BP     = SVGA_H_BP,
    parameter bit POL    = 1'b1,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_timing
        $error("timing_axis_counter: every timing parameter must be non-zero");
    end
    if (W < 1 || W > 30 || TOTAL > (1 << W)) begin : g_bad_width
        $error("timing_axis_counter: counter width too narrow for the axis total");
    end

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Decodes are of the pre-increment count; the top registers them.
    assign count  = count_q;
    assign wrap   = (count_q == LAST);
    assign active = (count_q < ACT_END);
    assign sync   = ((count_q >= SYNC_START) && (count_q < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised registered VGA sync generator with frame/line strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int HC_W     = cnt_width(SVGA_H_TOTAL),
    parameter int VC_W     = cnt_width(SVGA_V_TOTAL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pix_ce,
    output logic            hsync,
    output logic            vsync,
    output logic            video_on,
    output logic [HC_W-1:0] hcount,
    output logic [VC_W-1:0] vcount,
    output logic            sof,
    output logic            eol
);

    localparam logic [HC_W-1:0] H_LAST_ACT = HC_W'(H_ACTIVE - 1);

    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic            h_wrap, h_active, h_sync;
    logic            v_wrap, v_active, v_sync;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .W      (HC_W)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (pix_ce),
        .count  (h_cnt),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .W      (VC_W)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (pix_ce & h_wrap),
        .count  (v_cnt),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    logic [HC_W-1:0] hcount_q, hcount_d;
    logic [VC_W-1:0] vcount_q, vcount_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            video_on_q, video_on_d;
    logic            sof_q, sof_d;
    logic            eol_q, eol_d;

    // Everything holds between pixel enables except the strobes, which drop.
    always_comb begin
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        sof_d      = 1'b0;
        eol_d      = 1'b0;
        if (pix_ce) begin
            hcount_d   = h_cnt;
            vcount_d   = v_cnt;
            hsync_d    = h_sync;
            vsync_d    = v_sync;
            video_on_d = h_active & v_active;
            sof_d      = (h_cnt == '0) && (v_cnt == '0);
            eol_d      = (h_cnt == H_LAST_ACT) && v_active;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            hsync_q    <= ~H_POL;
            vsync_q    <= ~V_POL;
            video_on_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
        end
    end

    assign hcount   = hcount_q;
    assign vcount   = vcount_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign video_on = video_on_q;
    assign sof      = sof_q;
    assign eol      = eol_q;

    logic unused_wrap;
    assign unused_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen over default, inverted and tiny modes
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default SVGA mode
    logic        rst_a, ce_a, hs_a, vs_a, von_a, sof_a, eol_a;
    logic [10:0] hc_a;
    logic [9:0]  vc_a;

    // Default horizontal, short vertical, negative polarities
    logic        rst_b, ce_b, hs_b, vs_b, von_b, sof_b, eol_b;
    logic [10:0] hc_b;
    logic [3:0]  vc_b;

    // Tiny mode: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6)
    logic        rst_c, ce_c, hs_c, vs_c, von_c, sof_c, eol_c;
    logic [2:0]  hc_c;
    logic [2:0]  vc_c;

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .pix_ce(ce_a), .hsync(hs_a), .vsync(vs_a),
        .video_on(von_a), .hcount(hc_a), .vcount(vc_a), .sof(sof_a), .eol(eol_a)
    );

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(3), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .HC_W(11), .VC_W(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_ce(ce_b), .hsync(hs_b), .vsync(vs_b),
        .video_on(von_b), .hcount(hc_b), .vcount(vc_b), .sof(sof_b), .eol(eol_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HC_W(3), .VC_W(3)
    ) dut_c (
        .clk(clk), .reset(rst_c), .pix_ce(ce_c), .hsync(hs_c), .vsync(vs_c),
        .video_on(von_c), .hcount(hc_c), .vcount(vc_c), .sof(sof_c), .eol(eol_c)
    );

    typedef struct {
        logic ce;
        int   hc;
        int   vc;
        logic von;
        logic hs;
        logic vs;
        logic sof;
        logic eol;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_first, hs_last, hs_n, eol_hc, eol_n, von_n;
        int sof_t0, sof_t1, sof_n, hs_min, hs_max, vs_min, vs_max, vs_bad, vs_chg;
        int gap, n_eol, n_vs, n_von, n_hs, width_bad, hc_chg, hc_chg_idle, t_prev;
        logic prev_vs, prev_sof, prev_eol, found;
        logic [2:0] prev_hc;

        tbl[0]  = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ce_a = 1'b1; ce_b = 1'b1; ce_c = 1'b1;
        repeat (3) tick();

        chk("a_rst_hcount", hc_a, 0);
        chk("a_rst_vcount", vc_a, 0);
        chk("a_rst_hsync", hs_a, 0);
        chk("a_rst_vsync", vs_a, 0);
        chk("a_rst_video_on", von_a, 0);
        chk("a_rst_sof", sof_a, 0);
        chk("a_rst_eol", eol_a, 0);
        chk("b_rst_hsync", hs_b, 1);
        chk("b_rst_vsync", vs_b, 1);
        ce_b = 1'b0; ce_c = 1'b0;

        // Default mode: first line
        rst_a = 1'b0;
        tick();
        chk("a_first_hcount", hc_a, 0);
        chk("a_first_vcount", vc_a, 0);
        chk("a_first_video_on", von_a, 1);
        chk("a_first_sof", sof_a, 1);
        chk("a_first_hsync", hs_a, 0);
        hs_first = -1; hs_last = -1; hs_n = 0; eol_hc = -1; eol_n = 0; von_n = 0;
        for (int i = 0; i < 1047; i++) begin
            tick();
            if (hs_a) begin
                if (hs_first < 0) hs_first = int'(hc_a);
                hs_last = int'(hc_a);
                hs_n++;
            end
            if (eol_a) begin
                eol_hc = int'(hc_a);
                eol_n++;
            end
            if (von_a) von_n++;
        end
        chk("a_hsync_first", hs_first, 832);
        chk("a_hsync_last", hs_last, 895);
        chk("a_hsync_width", hs_n, 64);
        chk("a_eol_hcount", eol_hc, 799);
        chk("a_eol_count", eol_n, 1);
        chk("a_video_on_count", von_n, 799);
        chk("a_line_end_hcount", hc_a, 1047);

        // Reset inside hsync, with pix_ce still high
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (hc_a == 11'd850) found = 1'b1;
        end
        chk("a_reach_850", found, 1);
        chk("a_in_hsync", hs_a, 1);
        rst_a = 1'b1;
        tick();
        chk("a_midrst_hcount", hc_a, 0);
        chk("a_midrst_vcount", vc_a, 0);
        chk("a_midrst_hsync", hs_a, 0);
        chk("a_midrst_video_on", von_a, 0);
        chk("a_midrst_sof", sof_a, 0);
        rst_a = 1'b0;
        tick();
        chk("a_resume_sof", sof_a, 1);
        chk("a_resume_video_on", von_a, 1);
        chk("a_resume_hcount", hc_a, 0);
        ce_a = 1'b0;
        tick();
        chk("a_hold_hcount", hc_a, 0);
        chk("a_hold_sof_low", sof_a, 0);
        chk("a_hold_video_on", von_a, 1);

        // Negative-polarity mode across two frames
        rst_b = 1'b0; ce_b = 1'b1;
        sof_t0 = -1; sof_t1 = -1; sof_n = 0; eol_n = 0;
        hs_min = 9999; hs_max = -1; vs_min = 9999; vs_max = -1;
        vs_bad = 0; vs_chg = 0; prev_vs = 1'b1;
        for (int i = 0; i < 2 * 10480 + 4; i++) begin
            tick();
            if (sof_b) begin
                if (sof_n == 0) sof_t0 = i;
                else if (sof_n == 1) sof_t1 = i;
                sof_n++;
            end
            if (eol_b && i < 10480) eol_n++;
            if (!hs_b) begin
                if (int'(hc_b) < hs_min) hs_min = int'(hc_b);
                if (int'(hc_b) > hs_max) hs_max = int'(hc_b);
            end
            if (!vs_b) begin
                if (int'(vc_b) < vs_min) vs_min = int'(vc_b);
                if (int'(vc_b) > vs_max) vs_max = int'(vc_b);
            end
            if (vs_b != prev_vs) begin
                vs_chg++;
                if (hc_b != 11'd0) vs_bad++;
            end
            prev_vs = vs_b;
        end
        chk("b_sof_first", sof_t0, 0);
        chk("b_sof_period", sof_t1 - sof_t0, 10480);
        chk("b_sof_count", sof_n, 3);
        chk("b_eol_per_frame", eol_n, 4);
        chk("b_hsync_min", hs_min, 832);
        chk("b_hsync_max", hs_max, 895);
        chk("b_vsync_min", vs_min, 5);
        chk("b_vsync_max", vs_max, 7);
        chk("b_vsync_edges", vs_chg, 4);
        chk("b_vsync_edge_off_h0", vs_bad, 0);

        // Reset inside vsync
        found = 1'b0;
        for (int i = 0; i < 12000 && !found; i++) begin
            tick();
            if (hc_b == 11'd850 && vc_b == 4'd6) found = 1'b1;
        end
        chk("b_reach_850_6", found, 1);
        chk("b_in_vsync", vs_b, 0);
        rst_b = 1'b1;
        tick();
        chk("b_midrst_hsync", hs_b, 1);
        chk("b_midrst_vsync", vs_b, 1);
        chk("b_midrst_hcount", hc_b, 0);
        chk("b_midrst_vcount", vc_b, 0);
        chk("b_midrst_video_on", von_b, 0);
        rst_b = 1'b0;
        tick();
        chk("b_resume_sof", sof_b, 1);
        chk("b_resume_vcount", vc_b, 0);
        ce_b = 1'b0;

        // Tiny mode vector table
        rst_c = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ce_c = tbl[i].ce;
            tick();
            chk($sformatf("c_row%0d_hcount", i), hc_c, tbl[i].hc);
            chk($sformatf("c_row%0d_vcount", i), vc_c, tbl[i].vc);
            chk($sformatf("c_row%0d_video_on", i), von_c, tbl[i].von);
            chk($sformatf("c_row%0d_hsync", i), hs_c, tbl[i].hs);
            chk($sformatf("c_row%0d_vsync", i), vs_c, tbl[i].vs);
            chk($sformatf("c_row%0d_sof", i), sof_c, tbl[i].sof);
            chk($sformatf("c_row%0d_eol", i), eol_c, tbl[i].eol);
        end

        // Rest of the tiny frame up to the (7,5) corner, then the wrap
        ce_c = 1'b1;
        n_eol = 0; n_vs = 0; n_von = 0; n_hs = 0;
        for (int i = 0; i < 38; i++) begin
            tick();
            if (eol_c) n_eol++;
            if (vs_c) n_vs++;
            if (von_c) n_von++;
            if (hs_c) n_hs++;
        end
        chk("c_rest_eol", n_eol, 2);
        chk("c_rest_vsync", n_vs, 8);
        chk("c_rest_video_on", n_von, 6);
        chk("c_rest_hsync", n_hs, 10);
        chk("c_corner_hcount", hc_c, 7);
        chk("c_corner_vcount", vc_c, 5);
        tick();
        chk("c_wrap_hcount", hc_c, 0);
        chk("c_wrap_vcount", vc_c, 0);
        chk("c_wrap_sof", sof_c, 1);
        tick();
        chk("c_after_wrap_hcount", hc_c, 1);
        chk("c_after_wrap_vcount", vc_c, 0);
        chk("c_after_wrap_sof", sof_c, 0);

        // Tiny mode with pix_ce every 4th clk
        ce_c = 1'b0; rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        sof_n = 0; eol_n = 0; width_bad = 0; hc_chg = 0; hc_chg_idle = 0;
        gap = 0; t_prev = -1;
        prev_sof = 1'b0; prev_eol = 1'b0; prev_hc = hc_c;
        for (int i = 0; i < 3 * 192 + 8; i++) begin
            ce_c = (i % 4 == 0);
            tick();
            if (sof_c) begin
                if (t_prev >= 0 && (i - t_prev) != 192) gap++;
                t_prev = i;
                sof_n++;
            end
            if (eol_c) eol_n++;
            if ((sof_c && prev_sof) || (eol_c && prev_eol)) width_bad++;
            if (hc_c != prev_hc) begin
                hc_chg++;
                if (!ce_c) hc_chg_idle++;
            end
            prev_sof = sof_c;
            prev_eol = eol_c;
            prev_hc = hc_c;
        end
        chk("c4_sof_count", sof_n, 4);
        chk("c4_sof_period_bad", gap, 0);
        chk("c4_eol_count", eol_n, 9);
        chk("c4_strobe_width_bad", width_bad, 0);
        chk("c4_hcount_changes", hc_chg, 145);
        chk("c4_hcount_idle_changes", hc_chg_idle, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
